// File: rtl/fht_frame_sched.sv
// rtl/fht_frame_sched.sv - frame scheduler around the FHT core
// Bit-reversed bank load, core start with watchdog, and credited natural-order unload.
module fht_frame_sched #(
    parameter int A_BIT  = 8,
    parameter int D_BIT  = 16,
    parameter int RD_LAT = 1,
    parameter int TO_W   = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    output logic [3:0]       oWE_LOAD,
    output logic [A_BIT-1:0] oADDR_LOAD,
    output logic [D_BIT-1:0] oDATA_LOAD,
    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    output logic [1:0]       oRD_BANK,
    output logic [A_BIT-1:0] oADDR_RD,
    input  logic [D_BIT-1:0] iRD_DATA,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iOUT_READY,
    input  logic             iABORT,
    output logic             oBUSY,
    output logic             oERR
);
    localparam int NW    = A_BIT + 2;
    localparam int DEPTH = RD_LAT + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [NW-1:0]   N_LAST  = {NW{1'b1}};
    localparam logic [TO_W-1:0] WD_LAST = {TO_W{1'b1}} - 1'b1;
    localparam logic [TO_W-1:0] WB_LAST = TO_W'(7);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_RUN, S_UNLOAD, S_DRAIN
    } state_t;

    state_t            r_state, w_next;
    logic [NW-1:0]     r_n, r_m, w_rev;
    logic [TO_W-1:0]   r_wd;
    logic              r_err, r_start;
    logic [3:0]        r_we;
    logic [A_BIT-1:0]  r_addr_load;
    logic [D_BIT-1:0]  r_data_load;
    logic [RD_LAT-1:0] r_pipe;
    logic [D_BIT-1:0]  r_mem [DEPTH];
    logic [PW-1:0]     r_wp, r_rp;
    logic [CW-1:0]     r_occ, w_inflight;
    logic [CW:0]       w_commit;
    logic              w_take, w_issue, w_push, w_pop, w_timeout;

    assign w_take = (r_state == S_LOAD) && iVALID && !iABORT;
    assign w_push = r_pipe[RD_LAT-1];
    assign w_pop  = oVALID && iOUT_READY;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CW'(r_pipe[i]);
    end

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < NW; i++) w_rev[i] = r_n[NW-1-i];
    end

    // A pop this cycle frees its slot, so full-rate streaming never starves the issue side
    assign w_commit = (CW+1)'(r_occ) + (CW+1)'(w_inflight) - (CW+1)'(w_pop);
    assign w_issue  = (r_state == S_UNLOAD) && !iABORT && (w_commit < (CW+1)'(DEPTH));

    always_ff @(posedge iCLK) begin
        if (iRESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:      w_next = S_LOAD;
            S_LOAD:      if (w_take && r_n == N_LAST) w_next = S_START;
            S_START:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!iFHT_RDY) w_next = S_RUN;
                else if (r_wd == WB_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_RUN: begin
                if (iFHT_RDY) w_next = S_UNLOAD;
                else if (r_wd == WD_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_UNLOAD:    if (w_issue && r_m == N_LAST) w_next = S_DRAIN;
            S_DRAIN:     if (r_pipe == '0 && r_occ == '0) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (iABORT && r_state != S_IDLE) begin
            w_next    = S_IDLE;
            w_timeout = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_we        <= '0;
            r_addr_load <= '0;
            r_data_load <= '0;
            r_n         <= '0;
            r_m         <= '0;
            r_start     <= 1'b0;
            r_wd        <= '0;
            r_err       <= 1'b0;
            r_pipe      <= '0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_occ       <= '0;
        end else begin
            r_we <= '0;
            if (w_take) begin
                r_we        <= 4'b0001 << w_rev[NW-1:A_BIT];
                r_addr_load <= w_rev[A_BIT-1:0];
                r_data_load <= iDATA;
            end
            r_n     <= iABORT ? '0 : (w_take ? r_n + 1'b1 : r_n);
            r_m     <= iABORT ? '0 : (w_issue ? r_m + 1'b1 : r_m);
            r_start <= (r_state == S_START) && !iABORT;
            r_wd    <= ((r_state == S_WAIT_BUSY && iFHT_RDY) || r_state == S_RUN) ? r_wd + 1'b1 : '0;
            if (w_timeout)              r_err <= 1'b1;
            else if (r_state == S_IDLE) r_err <= 1'b0;
            if (iABORT) begin
                r_pipe <= '0;
                r_wp   <= '0;
                r_rp   <= '0;
                r_occ  <= '0;
            end else begin
                r_pipe[0] <= w_issue;
                for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
                if (w_push) r_wp <= (r_wp == PW'(DEPTH-1)) ? '0 : r_wp + 1'b1;
                if (w_pop)  r_rp <= (r_rp == PW'(DEPTH-1)) ? '0 : r_rp + 1'b1;
                r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (w_push && !iABORT) r_mem[r_wp] <= iRD_DATA;
    end

    assign oREADY     = (r_state == S_LOAD);
    assign oWE_LOAD   = r_we;
    assign oADDR_LOAD = r_addr_load;
    assign oDATA_LOAD = r_data_load;
    assign oFHT_START = r_start;
    assign oRD_BANK   = r_m[NW-1:A_BIT];
    assign oADDR_RD   = r_m[A_BIT-1:0];
    assign oVALID     = (r_occ != '0);
    assign oDATA      = oVALID ? r_mem[r_rp] : '0;
    assign oBUSY      = (r_state != S_IDLE);
    assign oERR       = r_err;
endmodule

// File: doc/fht_frame_sched.md
Name: fht_frame_sched

Overview:
- Frame-level scheduler wrapped around the FHT core (address/stage controller plus 4-bank RAM datapath).
- Accepts a stream of N = 4·2^A_BIT input samples and writes them into the four banks in bit-reversed order.
- Pulses the core start, then watches the core ready to detect completion, with a watchdog timeout.
- Streams the N results out in natural order with valid/ready backpressure.
- Sits between the system stream interfaces and the FHT core plus bank RAMs.

Parameters:
- A_BIT, 8: bank address width; N = 2^(A_BIT+2) points per frame.
- D_BIT, 16: sample width.
- RD_LAT, 1: bank RAM read latency in cycles (1..3).
- TO_W, 16: watchdog counter width; timeout fires at 2^TO_W - 1 cycles in RUN.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  synchronous active-high reset.
- iDATA  in  D_BIT  input sample.
- iVALID  in  1  input sample valid.
- oREADY  out  1  input accept; a transfer occurs when iVALID & oREADY.
- oWE_LOAD  out  4  one-hot bank write enable during load.
- oADDR_LOAD  out  A_BIT  load write address.
- oDATA_LOAD  out  D_BIT  load write data.
- oFHT_START  out  1  one-cycle start pulse to the core.
- iFHT_RDY  in  1  core ready (high when idle).
- oRD_BANK  out  2  bank select for the unload read mux.
- oADDR_RD  out  A_BIT  unload read address.
- iRD_DATA  in  D_BIT  muxed bank read data, RD_LAT cycles after the address.
- oDATA  out  D_BIT  result sample.
- oVALID  out  1  result valid.
- iOUT_READY  in  1  downstream accept.
- iABORT  in  1  abandon the current frame.
- oBUSY  out  1  high in any state other than IDLE.
- oERR  out  1  sticky watchdog timeout flag; cleared on reset or at the next LOAD entry.

Behaviour:
- Reset values: state IDLE; all outputs 0, including oREADY, oWE_LOAD, oFHT_START, oVALID, oBUSY and oERR.
- States: IDLE, LOAD, START, WAIT_BUSY, RUN, UNLOAD, DRAIN.
- IDLE -> LOAD: on the first cycle after reset release, or after DRAIN/abort completes. oREADY = 1 only in LOAD.
- LOAD: on each transfer with sample index n (A_BIT+2 bits, 0..N-1):
  - p = bitreverse(n); bank = p[A_BIT+1:A_BIT]; addr = p[A_BIT-1:0].
  - oWE_LOAD[bank], oADDR_LOAD and oDATA_LOAD are registered; write is issued 1 cycle after the handshake.
  - Transfer of n = N-1 -> START; oREADY drops in the same cycle the state changes.
- START: oFHT_START = 1 for exactly one cycle -> WAIT_BUSY.
- WAIT_BUSY:
  - Waits for iFHT_RDY = 0, so a stale high ready is never taken as completion.
  - iFHT_RDY low -> RUN, watchdog cleared.
  - Still high after 8 cycles -> oERR = 1 -> IDLE.
- RUN:
  - Watchdog increments every cycle.
  - iFHT_RDY = 1 -> UNLOAD.
  - Watchdog reaching all-ones -> oERR = 1 -> IDLE.
- UNLOAD:
  - Read index m = 0..N-1 in natural order: oRD_BANK = m[A_BIT+1:A_BIT], oADDR_RD = m[A_BIT-1:0].
  - Returned data enters an output FIFO of depth RD_LAT+1.
  - Credit rule: a read is issued only when (FIFO occupancy + reads in flight) < RD_LAT+1. The FIFO therefore never overflows, and oVALID stalls only for backpressure.
  - oDATA/oVALID come from the FIFO head; pop on oVALID & iOUT_READY.
  - Issue of m = N-1 -> DRAIN.
- DRAIN: after the in-flight reads land and the FIFO is empty -> IDLE, which re-enters LOAD on the next cycle.
- With iOUT_READY held high, throughput is 1 sample/cycle; first oVALID appears RD_LAT+1 cycles after UNLOAD entry.
- Simultaneous FIFO push and pop: occupancy is unchanged.
- iABORT (any state except IDLE), next cycle:
  - Clears the FIFO and pending reads, drops oVALID and oREADY, goes to IDLE; no oFHT_START is emitted.
  - Abort in the same cycle as an input handshake: the handshake is discarded and no write is issued.
  - Abort during RUN: the core is left to finish, and the next frame waits in WAIT_BUSY as normal.
- Counters wrap to 0 at frame end; n and m never exceed N-1.
- Reset mid-operation: immediate return to reset values at the next edge; no partial write is issued after reset asserts.

Test Plan:
- A_BIT=2 (N=16), load samples 0..15 with iVALID held high -> oREADY high for 16 transfers. Sample n=1 writes bank 2, addr 0; n=6 (0110, reversed 0110) writes bank 1, addr 2; oFHT_START pulses once, 1 cycle after the last write.
- Core model drops iFHT_RDY 3 cycles after start and raises it 200 cycles later -> UNLOAD entered. With iOUT_READY high, oVALID holds for 16 consecutive cycles, m = 0..15 in order, first valid at UNLOAD+RD_LAT+1.
- iOUT_READY toggled 1-0-0-1 randomly, RD_LAT=3 -> no lost or duplicated sample; FIFO occupancy never exceeds 4; order is preserved.
- Core never drops iFHT_RDY -> oERR=1 after 8 WAIT_BUSY cycles, then IDLE and LOAD; oERR clears on LOAD entry.
- TO_W=6, iFHT_RDY held low -> oERR set on cycle 63 of RUN, no oVALID issued.
- iABORT asserted at load sample 7 and again mid-UNLOAD with 2 reads in flight -> no oFHT_START; oVALID low on the next cycle; the following frame loads from n=0.
